div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M integer divider for the EX stage of the pipelined core. It consumes the two register-file read operands forwarded from ID/EX and computes DIV, DIVU, REM or REMU over WIDTH+1 cycles. It uses a start/busy/done handshake so the hazard unit can stall the front of the pipeline. The result returns to the EX/MEM register and from there to the register-file write port.

## Interface
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or FIN.
- kill  input  1  pipeline flush; aborts any operation in progress.
- op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  WIDTH  dividend, taken from rd0.
- b  input  WIDTH  divisor, taken from rd1.
- busy  output  1  an operation is in progress; the core must stall.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  quotient or remainder, held until the next accepted start.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - FIN: result ready, done asserted.
- IDLE/FIN to CALC: start=1 and kill=0 with a normal operand pair.
  - Latch op and the sign flags.
  - Latch |a| and |b| for signed ops; latch a and b directly for unsigned ops.
  - Clear the partial remainder and the iteration counter.
- IDLE/FIN to FIN directly: start=1 and kill=0 with a special operand pair. Result is written at that edge.
  - b==0: quotient = all ones; remainder = a unchanged. Applies to both signed and unsigned ops.
  - Signed overflow (DIV/REM, a==0x80000000, b==0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC: one restoring-division step per cycle, MSB first.
  - Shift the remainder left and shift in the next dividend bit.
  - Trial-subtract the divisor; the quotient bit is 1 if the difference is non-negative, and the difference is kept; otherwise 0.
  - The counter runs 0..WIDTH-1. On the step with counter==WIDTH-1, go to FIN and write result with the sign fixed.
- Sign fix, signed ops only:
  - Quotient is negated when the operand signs differ.
  - Remainder is negated when a is negative.
  - Invariant: remainder sign equals dividend sign, and a = q*b + r.
- FIN to IDLE: when start=0.
- Simultaneous events:
  - start asserted during CALC is ignored; no queuing.
  - kill has priority over start in every state.
  - kill in CALC or FIN forces IDLE at the next edge. done is not asserted for a killed operation, and result is not updated.
- Widths: internal partial remainder is WIDTH+1 bits to hold the subtraction borrow. Negation is two's complement, modulo 2^WIDTH.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, counter=0.
- Reset asserted mid-operation aborts immediately. No done is produced, and result reads 0.
- busy=1 exactly while the state is CALC.
- done=1 exactly while the state is FIN. Both outputs are registered, with no combinational path from the inputs.
- Normal latency, with start high in cycle 0:
  - Cycles 1..WIDTH are CALC, with busy=1.
  - Cycle WIDTH+1 is FIN: done=1, busy=0, result valid.
  - This is cycle 33 for the default width.
- Special-case latency: done=1 and result valid in cycle 1. busy is never asserted.
- Back-to-back operation: start held high in the FIN cycle is accepted. done drops the next cycle and busy rises.
- If start stays high after acceptance, it does not retrigger until the state is FIN again.
- result is stable from the FIN cycle until the edge that accepts the next start. It is not disturbed by CALC activity.

## Test plan
- DIV a=0xFFFFFFF9 (-7), b=2 -> done in cycle 33, result=0xFFFFFFFD (-3). Same operands with REM -> 0xFFFFFFFF (-1).
- DIVU a=100, b=7 -> result=14 in cycle 33, with busy high for cycles 1..32. REMU with the same operands -> 2.
- Specials:
  - DIV a=5, b=0 -> result 0xFFFFFFFF in cycle 1, busy never high.
  - REM a=5, b=0 -> result 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Assert rst in cycle 10 of a DIVU -> busy=0, done=0 and result=0 immediately. No done pulse follows.
- Assert kill in cycle 20 of a DIVU -> IDLE next cycle, no done, and result holds the previous value.
- start held high in the FIN cycle -> second operation accepted. Its done arrives 33 cycles later, and the first result stays valid until that acceptance edge.
- Randomized signed and unsigned operand pairs compared against a reference model.

Source files
------------

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit
//  Purpose  : Iterative RV32M DIV/DIVU/REM/REMU unit, one restoring step/cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int               CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             remsel_q, remsel_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             signed_op, div_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;
  logic [WIDTH:0]   rem_shift, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fix, quo_fix;

  assign signed_op   = ~op[0];
  assign div_zero    = (b == '0);
  assign ovf         = signed_op & (a == SMIN) & (b == '1);
  assign a_abs       = (signed_op & a[WIDTH-1]) ? -a : a;
  assign b_abs       = (signed_op & b[WIDTH-1]) ? -b : b;
  assign special_res = ovf ? (op[1] ? '0 : SMIN) : (op[1] ? a : '1);

  // The dividend register shifts out its MSB each step and takes the quotient bit in at the LSB.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign qbit      = ~diff[WIDTH];
  assign rem_step  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {dvd_q[WIDTH-2:0], qbit};
  assign quo_fix   = negq_q ? -quo_step : quo_step;
  assign rem_fix   = negr_q ? -rem_step : rem_step;

  always_comb begin
    state_d  = state_q;
    remsel_d = remsel_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (kill || !start) begin
          state_d = S_IDLE;
        end else if (div_zero || ovf) begin
          state_d  = S_FIN;
          result_d = special_res;
        end else begin
          state_d  = S_CALC;
          remsel_d = op[1];
          negq_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_d   = signed_op & a[WIDTH-1];
          dvd_d    = a_abs;
          dvs_d    = b_abs;
          rem_d    = '0;
          cnt_d    = '0;
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d  = S_FIN;
            result_d = remsel_q ? rem_fix : quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remsel_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remsel_q <= remsel_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_FIN);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Directed and randomized self-checking bench for div_unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_result;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic (SV division truncates toward zero).
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!o[0]) begin
      if (x == MIN && y == 32'hFFFF_FFFF) begin
        q = MIN;
        r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] exp;
    bit          special, moved;
    int          cyc, bcnt;
    exp     = ref_model(o, x, y);
    special = (y == 32'd0) || (!o[0] && x == MIN && y == 32'hFFFF_FFFF);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; bcnt = 0; moved = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      if (result !== last_result) moved = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), special ? 32'd1 : 32'd33);
    check({tag, "_busy_cycles"}, 32'(bcnt), special ? 32'd0 : 32'd32);
    check({tag, "_busy_in_fin"}, {31'd0, busy}, 32'd0);
    check({tag, "_result_held"}, {31'd0, moved}, 32'd0);
    check({tag, "_result"}, result, exp);
    last_result = exp;
    tick();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int          cyc, dcnt;
    logic [31:0] e1, e2, x, y;
    logic [1:0]  o;

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; a = '0; b = '0;
    last_result = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    run_op("div_neg7_2",  2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_neg7_2",  2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7",  2'b01, 32'd100, 32'd7);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7);
    run_op("div_by_zero", 2'b00, 32'd5, 32'd0);
    run_op("rem_by_zero", 2'b10, 32'd5, 32'd0);
    run_op("divu_by_zero", 2'b01, 32'hDEAD_BEEF, 32'd0);
    run_op("remu_by_zero", 2'b11, 32'hDEAD_BEEF, 32'd0);
    run_op("div_ovf",     2'b00, MIN, 32'hFFFF_FFFF);
    run_op("rem_ovf",     2'b10, MIN, 32'hFFFF_FFFF);
    run_op("divu_min_m1", 2'b01, MIN, 32'hFFFF_FFFF);
    run_op("rem_7_neg2",  2'b10, 32'd7, 32'hFFFF_FFFE);

    // Reset in cycle 10 of a DIVU aborts with no later done.
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    #2;
    rst = 1'b0;
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    check("rst_no_done", 32'(dcnt), 32'd0);
    last_result = 32'd0;

    // Kill in cycle 20 of a DIVU: idle next cycle, result untouched.
    run_op("pre_kill", 2'b01, 32'd1000, 32'd3);
    op = 2'b01; a = 32'd55; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    check("kill_result", result, 32'd333);
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    check("kill_no_done", 32'(dcnt), 32'd0);

    // Back-to-back with start held high throughout the first operation.
    e1 = ref_model(2'b00, 32'h1234_5678, 32'hFFFF_FEDD);
    e2 = ref_model(2'b11, 32'hCAFE_F00D, 32'd1234);
    op = 2'b00; a = 32'h1234_5678; b = 32'hFFFF_FEDD; start = 1'b1;
    tick();
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b_first_latency", 32'(cyc), 32'd33);
    check("b2b_first_result", result, e1);
    op = 2'b11; a = 32'hCAFE_F00D; b = 32'd1234;
    tick();
    start = 1'b0;
    check("b2b_accept_done", {31'd0, done}, 32'd0);
    check("b2b_accept_busy", {31'd0, busy}, 32'd1);
    check("b2b_result_kept", result, e1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b_second_latency", 32'(cyc), 32'd33);
    check("b2b_second_result", result, e2);
    last_result = e2;
    tick();

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = MIN; y = 32'hFFFF_FFFF; end
        2, 3: y = 32'($urandom_range(1, 255));
        4: y = -32'($urandom_range(1, 255));
        5: x = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op("rand", o, x, y);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
